// File: rtl/piece_queue.sv
// Preview queue of tetromino IDs fed by the free-running randomizer, with anti-repeat dealing.
// Define PIECE_QUEUE_BAG_EN to replace anti-repeat with 7-bag dealing.
module piece_queue #(
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             random_in,
  input  logic                   pop,
  output logic [2:0]             piece,
  output logic                   piece_valid,
  output logic [3*(DEPTH-1)-1:0] preview,
  output logic                   full,
  output logic [3:0]             count
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [2:0] q     [DEPTH];
  logic [2:0] q_nxt [DEPTH];
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] last_enq;
  logic [2:0] cand;
  logic       pop_ok, enq;
  int         wr_idx;

  function automatic logic [2:0] map_zero(input logic [2:0] r);
    map_zero = (r == 3'd0) ? 3'd1 : r;
  endfunction

  function automatic logic [2:0] next_id(input logic [2:0] id);
    next_id = (id == 3'd7) ? 3'd1 : id + 3'd1;
  endfunction

`ifdef PIECE_QUEUE_BAG_EN
  logic [6:0] used, used_set;

  // First ID not yet dealt in this bag, searching upward from s with 7 wrapping to 1.
  function automatic logic [2:0] bag_pick(input logic [2:0] s, input logic [6:0] u);
    logic [2:0] id;
    logic       found;
    bag_pick = s;
    found    = 1'b0;
    id       = s;
    for (int k = 0; k < 7; k++) begin
      if (!found && !u[id - 3'd1]) begin
        bag_pick = id;
        found    = 1'b1;
      end
      id = next_id(id);
    end
  endfunction

  assign cand     = bag_pick(map_zero(random_in), used);
  assign used_set = used | (7'd1 << (cand - 3'd1));

  always_ff @(posedge clk) begin
    if (rst)
      used <= 7'd0;
    else if (enq)
      used <= (used_set == 7'h7f) ? 7'd0 : used_set;
  end
`else
  function automatic logic [2:0] anti_repeat(input logic [2:0] s, input logic [2:0] last);
    anti_repeat = (s == last) ? next_id(s) : s;
  endfunction

  assign cand = anti_repeat(map_zero(random_in), last_enq);
`endif

  assign pop_ok = pop && (cnt != 4'd0);
  assign enq    = (cnt < DEPTH_C) || pop_ok;
  assign wr_idx = int'(cnt) - (pop_ok ? 1 : 0);

  // Shift on pop, then drop the new candidate into the first free slot.
  always_comb begin
    q_nxt = q;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++)
        q_nxt[i] = q[i+1];
      q_nxt[DEPTH-1] = 3'd0;
    end
    if (enq) begin
      for (int i = 0; i < DEPTH; i++)
        if (i == wr_idx)
          q_nxt[i] = cand;
    end
    cnt_nxt = cnt + {3'd0, enq} - {3'd0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= 3'd0;
      cnt      <= 4'd0;
      last_enq <= 3'd0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      if (enq)
        last_enq <= cand;
    end
  end

  always_comb begin
    preview = '0;
    for (int k = 1; k < DEPTH; k++)
      preview[3*k-3 +: 3] = q[k];
  end

  assign piece       = q[0];
  assign piece_valid = (cnt != 4'd0);
  assign full        = (cnt == DEPTH_C);
  assign count       = cnt;

endmodule

// File: tb/tb_piece_queue.sv
// Scoreboard bench for piece_queue: directed plan scenarios plus random traffic against a queue model.
module tb_piece_queue;

  localparam int DEPTH = 3;
  localparam int PW    = 3 * (DEPTH - 1);

  logic          clk;
  logic          rst;
  logic [2:0]    random_in;
  logic          pop;
  logic [2:0]    piece;
  logic          piece_valid;
  logic [PW-1:0] preview;
  logic          full;
  logic [3:0]    count;

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .random_in(random_in), .pop(pop),
    .piece(piece), .piece_valid(piece_valid), .preview(preview),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    piece;
    logic          valid;
    logic [PW-1:0] preview;
    logic          full;
    logic [3:0]    count;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a plain queue of dealt IDs plus the dealing history.
  int   mq[$];
  int   m_last;
  bit   m_used[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int deal(input int r);
    int s, c;
    bit all;
    s = (r == 0) ? 1 : r;
`ifdef PIECE_QUEUE_BAG_EN
    c = s;
    while (m_used[c]) c = (c % 7) + 1;
    m_used[c] = 1'b1;
    all = 1'b1;
    for (int i = 1; i <= 7; i++) if (!m_used[i]) all = 1'b0;
    if (all) for (int i = 1; i <= 7; i++) m_used[i] = 1'b0;
`else
    all = 1'b0;
    c = (s == m_last) ? (s % 7) + 1 : s;
`endif
    m_last = c;
    return c;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.piece   = (mq.size() > 0) ? 3'(mq[0]) : 3'd0;
    e.valid   = (mq.size() > 0);
    e.preview = '0;
    for (int k = 1; k < mq.size(); k++) e.preview[3*k-3 +: 3] = 3'(mq[k]);
    e.full    = (mq.size() == DEPTH);
    e.count   = 4'(mq.size());
    return e;
  endfunction

  task automatic step(input logic r, input logic [2:0] rin, input logic p);
    @(negedge clk);
    rst = r; random_in = rin; pop = p;
    if (r) begin
      mq.delete();
      m_last = 0;
      for (int i = 0; i < 8; i++) m_used[i] = 1'b0;
    end else begin
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < DEPTH) mq.push_back(deal(int'(rin)));
    end
    sb.push_back(snapshot());
  endtask

  // Monitor: every edge after the first issued cycle has one expected entry waiting.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("piece",       32'(piece),       32'(e.piece));
        check("piece_valid", 32'(piece_valid), 32'(e.valid));
        check("preview",     32'(preview),     32'(e.preview));
        check("full",        32'(full),        32'(e.full));
        check("count",       32'(count),       32'(e.count));
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; random_in = 3'd0; pop = 1'b0;
    m_last = 0;

    // Fill from reset with a held value, then pop with a new value.
    step(1, 3, 0); step(1, 3, 0);
    step(0, 3, 0); step(0, 3, 0); step(0, 3, 0);
`ifndef PIECE_QUEUE_BAG_EN
    @(posedge clk); #2;
    check("s1_head",    32'(piece),   32'd3);
    check("s1_preview", 32'(preview), 32'({3'd3, 3'd4}));
    check("s1_count",   32'(count),   32'd3);
`endif
    step(0, 5, 1);
`ifndef PIECE_QUEUE_BAG_EN
    @(posedge clk); #2;
    check("s3_head",    32'(piece),   32'd4);
    check("s3_preview", 32'(preview), 32'({3'd5, 3'd3}));
`endif

    // Wrap from 7 and zero mapping.
    step(1, 0, 0); step(0, 7, 0); step(0, 7, 0); step(0, 7, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // Pop on the first cycle after release is ignored.
    step(1, 0, 0); step(0, 2, 1); step(0, 2, 0);

    // Reset together with pop on a full queue, then refill.
    step(0, 6, 0); step(0, 6, 0);
    step(1, 1, 1);
    step(0, 4, 0); step(0, 4, 0); step(0, 4, 0);

    // Held input with pops every cycle exercises dealing sequence over several bags.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 2, 0);
    for (int i = 0; i < 20; i++) step(0, 2, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    rst = 1'b0; pop = 1'b0;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
